// File: rtl/id_pkg.sv
// Shared decode-stage types and constants for the serial issue controller.
package id_pkg;
  localparam int REG_W = 5;

  // ALU control codes the decoder uses to recognise LL/SC (no simulator notify).
  localparam logic [5:0] ALU_LL = 6'b101000;
  localparam logic [5:0] ALU_SC = 6'b110110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    NOTIFY  = 2'd2,
    RELEASE = 2'd3
  } id_state_e;
endpackage

// File: rtl/id_ld_hazard_cmp.sv
// Load-use comparator: flags a source operand matching any in-flight load destination.
module id_ld_hazard_cmp #(
  parameter int NUM_LD_SRC = 2,
  parameter int REG_W      = 5
) (
  input  logic [REG_W-1:0]            src_a_i,
  input  logic [REG_W-1:0]            src_b_i,
  input  logic                        uses_a_i,
  input  logic                        uses_b_i,
  input  logic [NUM_LD_SRC*REG_W-1:0] ld_reg_i,
  input  logic [NUM_LD_SRC-1:0]       ld_valid_i,
  output logic                        hazard_a_o,
  output logic                        hazard_b_o
);
  logic [NUM_LD_SRC-1:0] hit_a, hit_b;

  for (genvar i = 0; i < NUM_LD_SRC; i++) begin : g_ent
    assign hit_a[i] = ld_valid_i[i] && (ld_reg_i[i*REG_W +: REG_W] == src_a_i);
    assign hit_b[i] = ld_valid_i[i] && (ld_reg_i[i*REG_W +: REG_W] == src_b_i);
  end

  // r0 is hardwired, so a load "to" r0 never produces a real dependency.
  assign hazard_a_o = uses_a_i && (src_a_i != '0) && (|hit_a);
  assign hazard_b_o = uses_b_i && (src_b_i != '0) && (|hit_b);
endmodule

// File: rtl/id_serial_issue_ctrl.sv
// Decode issue controller: per-cycle issue/bubble/serial-marker choice, serial drain FSM
// and load-use interlock in front of the ID/EXE register.
module id_serial_issue_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int NUM_LD_SRC   = 2,
  parameter int REG_W        = id_pkg::REG_W
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        stall,
  input  logic                        instr_valid,
  input  logic                        is_serial,
  input  logic                        notify_sim,
  input  logic [REG_W-1:0]            src_a,
  input  logic [REG_W-1:0]            src_b,
  input  logic                        uses_a,
  input  logic                        uses_b,
  input  logic [NUM_LD_SRC*REG_W-1:0] ld_reg,
  input  logic [NUM_LD_SRC-1:0]       ld_valid,
  output logic                        issue,
  output logic                        bubble,
  output logic                        pass_serial,
  output logic                        WANT_FREEZE,
  output logic                        SYS,
  output logic                        busy
);
  import id_pkg::*;

  id_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       notify_q, notify_d;
  logic       issue_q, issue_d, bubble_q, bubble_d, pass_q, pass_d;
  logic       haz_a, haz_b, hazard, serial_acc;

  id_ld_hazard_cmp #(.NUM_LD_SRC(NUM_LD_SRC), .REG_W(REG_W)) u_haz (
    .src_a_i    (src_a),
    .src_b_i    (src_b),
    .uses_a_i   (uses_a),
    .uses_b_i   (uses_b),
    .ld_reg_i   (ld_reg),
    .ld_valid_i (ld_valid),
    .hazard_a_o (haz_a),
    .hazard_b_o (haz_b)
  );

  assign serial_acc = instr_valid && is_serial;
  assign hazard     = instr_valid && !is_serial && (haz_a || haz_b);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    notify_d = notify_q;
    issue_d  = issue_q;
    bubble_d = bubble_q;
    pass_d   = pass_q;
    if (!stall) begin
      issue_d  = 1'b0;
      bubble_d = 1'b1;
      pass_d   = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (serial_acc) begin
            pass_d   = 1'b1;
            bubble_d = 1'b0;
            cnt_d    = 4'(DRAIN_CYCLES - 2);
            notify_d = notify_sim;
            state_d  = DRAIN;
          end else if (!hazard) begin
            issue_d  = instr_valid;
            bubble_d = !instr_valid;
          end
        end
        DRAIN: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = NOTIFY;
        end
        NOTIFY:  state_d = RELEASE;
        // The held serial instruction is consumed here; no re-sample of is_serial.
        RELEASE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      notify_q <= 1'b0;
      issue_q  <= 1'b0;
      bubble_q <= 1'b1;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      notify_q <= notify_d;
      issue_q  <= issue_d;
      bubble_q <= bubble_d;
      pass_q   <= pass_d;
    end
  end

  assign issue       = issue_q;
  assign bubble      = bubble_q;
  assign pass_serial = pass_q;
  assign SYS         = (state_q == NOTIFY) && notify_q;
  assign busy        = (state_q != IDLE);
  assign WANT_FREEZE = ((state_q == IDLE) && (hazard || serial_acc)) ||
                       (state_q == DRAIN) || (state_q == NOTIFY);
endmodule

// File: tb/tb_id_serial_issue_ctrl.sv
// Directed bench for id_serial_issue_ctrl with DRAIN_CYCLES=4, two load sources.
module tb_id_serial_issue_ctrl;
  localparam int NL = 2;
  localparam int RW = 5;

  logic CLK = 1'b0;
  logic RESET, stall, instr_valid, is_serial, notify_sim, uses_a, uses_b;
  logic [RW-1:0] src_a, src_b;
  logic [NL*RW-1:0] ld_reg;
  logic [NL-1:0] ld_valid;
  logic issue, bubble, pass_serial, WANT_FREEZE, SYS, busy;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  id_serial_issue_ctrl #(.DRAIN_CYCLES(4), .NUM_LD_SRC(NL), .REG_W(RW)) dut (
    .CLK(CLK), .RESET(RESET), .stall(stall), .instr_valid(instr_valid),
    .is_serial(is_serial), .notify_sim(notify_sim), .src_a(src_a), .src_b(src_b),
    .uses_a(uses_a), .uses_b(uses_b), .ld_reg(ld_reg), .ld_valid(ld_valid),
    .issue(issue), .bubble(bubble), .pass_serial(pass_serial),
    .WANT_FREEZE(WANT_FREEZE), .SYS(SYS), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_serial(input logic n);
    instr_valid = 1'b1; is_serial = 1'b1; notify_sim = n;
    uses_a = 1'b0; uses_b = 1'b0; ld_valid = '0;
  endtask

  // Expects serial inputs already presented in IDLE; runs accept through return to IDLE.
  task automatic run_serial(input string tag, input logic n);
    #1 chk({tag, "_wf_idle"}, WANT_FREEZE, 1);
    step();
    chk({tag, "_pass"}, {issue, bubble, pass_serial}, 3'b001);
    chk({tag, "_busy1"}, busy, 1);
    step();
    chk({tag, "_drain"}, {bubble, WANT_FREEZE, SYS, busy}, 4'b1101);
    step();
    chk({tag, "_notify"}, {bubble, WANT_FREEZE, SYS, busy}, {1'b1, 1'b1, n, 1'b1});
    step();
    chk({tag, "_release"}, {bubble, WANT_FREEZE, SYS, busy}, 4'b1001);
    instr_valid = 1'b0; is_serial = 1'b0;
    step();
    chk({tag, "_idle"}, {issue, bubble, pass_serial, busy, SYS}, 5'b01000);
  endtask

  initial begin
    RESET = 1'b1; stall = 1'b0; instr_valid = 1'b0; is_serial = 1'b0; notify_sim = 1'b0;
    src_a = '0; src_b = '0; uses_a = 1'b0; uses_b = 1'b0; ld_reg = '0; ld_valid = '0;
    step(); step();
    chk("rst_outs", {issue, bubble, pass_serial}, 3'b010);
    chk("rst_sys_busy", {SYS, busy}, 2'b00);
    RESET = 1'b0;

    // Plain issue
    instr_valid = 1'b1; src_a = 5'd3; uses_a = 1'b1;
    #1 chk("plain_wf", WANT_FREEZE, 0);
    step();
    chk("plain_issue", {issue, bubble, pass_serial, SYS}, 4'b1000);

    // Syscall then back-to-back SC
    set_serial(1'b1);
    run_serial("sys", 1'b1);
    set_serial(1'b0);
    run_serial("sc", 1'b0);

    // Load-use on entry 1 via src_b
    instr_valid = 1'b1; is_serial = 1'b0; uses_a = 1'b0; uses_b = 1'b1; src_b = 5'd8;
    ld_reg = {5'd8, 5'd0}; ld_valid = 2'b10;
    #1 chk("haz_b_wf", WANT_FREEZE, 1);
    step();
    chk("haz_b_bubble", {issue, bubble, pass_serial, busy}, 4'b0100);
    ld_valid = 2'b00;
    #1 chk("haz_clr_wf", WANT_FREEZE, 0);
    step();
    chk("haz_clr_issue", {issue, bubble}, 2'b10);
    // Load-use on entry 0 via src_a
    uses_a = 1'b1; uses_b = 1'b0; src_a = 5'd5; ld_reg = {5'd9, 5'd5}; ld_valid = 2'b01;
    #1 chk("haz_a_wf", WANT_FREEZE, 1);
    step();
    chk("haz_a_bubble", {issue, bubble}, 2'b01);
    // r0 never hazards
    src_a = 5'd0; src_b = 5'd0; uses_b = 1'b1; ld_reg = '0; ld_valid = 2'b11;
    #1 chk("r0_wf", WANT_FREEZE, 0);
    step();
    chk("r0_issue", {issue, bubble}, 2'b10);

    // Stall right after acceptance: 3 frozen edges, then remaining drain
    set_serial(1'b1);
    step();
    chk("stl_pass", pass_serial, 1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stl_hold%0d", i), {issue, bubble, pass_serial, busy, SYS, WANT_FREEZE},
          6'b001101);
    end
    stall = 1'b0;
    step();
    chk("stl_drain", {bubble, SYS, busy}, 3'b101);
    step();
    chk("stl_notify", SYS, 1);
    step();
    chk("stl_release", {WANT_FREEZE, busy}, 2'b01);
    instr_valid = 1'b0; is_serial = 1'b0;
    step();
    chk("stl_idle", busy, 0);

    // Reset during NOTIFY, then a full restart
    set_serial(1'b1);
    step(); step(); step();
    chk("rn_notify", SYS, 1);
    RESET = 1'b1;
    step();
    chk("rn_after", {SYS, busy, bubble, pass_serial, issue}, 5'b00100);
    RESET = 1'b0;
    run_serial("rn_re", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_serial_issue_ctrl.md
Name: id_serial_issue_ctrl

Overview:
- Parametrised issue controller for the decode stage. It generalises the fixed 4-cycle syscall bubble counter into a DRAIN_CYCLES-deep serialisation FSM, used for syscall and LL/SC flushes.
- It adds a load-use interlock across NUM_LD_SRC pending-load sources.
- It sits between the decoder and the ID/EXE pipeline register. Each cycle it decides issue, bubble or serial-marker, and drives WANT_FREEZE and SYS.

Parameters:
- DRAIN_CYCLES, 4, non-stalled cycles from serial acceptance to release. Legal values are 3..15.
- NUM_LD_SRC, 2, number of in-flight load-destination sources checked for load-use hazards.
- REG_W, 5, register index width.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- stall  in  1  global hold; all state and registered outputs freeze while it is high.
- instr_valid  in  1  ID holds a valid instruction.
- is_serial  in  1  decoded instruction is serialising (syscall, LL, SC).
- notify_sim  in  1  serial op requires a SYS pulse (0 for LL/SC).
- src_a  in  REG_W  rs index.
- src_b  in  REG_W  rt index.
- uses_a  in  1  instruction reads src_a.
- uses_b  in  1  instruction reads src_b.
- ld_reg  in  NUM_LD_SRC*REG_W  packed destinations of in-flight loads; entry i is bits [i*REG_W +: REG_W].
- ld_valid  in  NUM_LD_SRC  per-entry valid.
- issue  out  1  registered; latch the decoded instruction into ID/EXE.
- bubble  out  1  registered; latch a NOP into ID/EXE.
- pass_serial  out  1  registered; latch a marker carrying only the opcode and ALU control, so that MEM flushes.
- WANT_FREEZE  out  1  combinational; fetch holds its PC.
- SYS  out  1  Moore decode of state; tells the simulator to service the call.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (RESET=1 at a CLK edge):
  - State goes to IDLE; cnt=0; notify_q=0.
  - issue=0, bubble=1, pass_serial=0.
  - SYS=0 and busy=0.
  - Reset overrides stall. Reset mid-drain returns the block to IDLE with SYS low on the next cycle.
- Exactly one of issue/bubble/pass_serial is high after every non-stalled edge.
- States: IDLE, DRAIN, NOTIFY, RELEASE.
- Hazard: instr_valid & ~is_serial & ((uses_a & src_a!=0 & any_i(ld_valid[i] & ld_reg[i]==src_a)) | the same term for b). Register 0 never hazards.
- IDLE, accept serial (instr_valid & is_serial):
  - pass_serial<=1.
  - cnt<=DRAIN_CYCLES-2; notify_q<=notify_sim.
  - Next state DRAIN.
- IDLE, hazard: bubble<=1; stay in IDLE.
- IDLE, otherwise: issue<=instr_valid, bubble<=~instr_valid.
- DRAIN:
  - bubble<=1 and cnt<=cnt-1.
  - When cnt==1, move to NOTIFY.
- NOTIFY: SYS=notify_q; bubble<=1; next state RELEASE.
- RELEASE:
  - bubble<=1, which consumes the held serial instruction.
  - Next state IDLE. is_serial is not re-sampled here, so there is no re-trigger.
- WANT_FREEZE = (IDLE & (hazard | instr_valid&is_serial)) | DRAIN | NOTIFY. It is low in RELEASE so fetch advances exactly one instruction.
- Cycle count: acceptance to return to IDLE is DRAIN_CYCLES non-stalled edges. DRAIN lasts DRAIN_CYCLES-2 cycles, NOTIFY 1, RELEASE 1.
- A stall cycle does not count toward the drain.
- Back-to-back serials: a serial arriving in the IDLE cycle right after RELEASE is accepted normally.
- Counter width is 4 bits. cnt never underflows, because DRAIN exits at 1.
- A hazard and a serial are never both flagged; the serial path wins.

Decomposition:
- Shared package id_pkg holds:
  - state enum (IDLE/DRAIN/NOTIFY/RELEASE);
  - REG_W;
  - ALU control constants for LL (6'b101000) and SC (6'b110110), which the decoder uses to derive notify_sim.
- One natural sub-module, id_ld_hazard_cmp: parametrised NUM_LD_SRC comparator that returns hazard_a/hazard_b.

Test Plan:
- Reset, then valid non-serial instr with no loads -> next edge issue=1, bubble=0, WANT_FREEZE=0, SYS=0.
- Syscall (notify_sim=1), DRAIN_CYCLES=4:
  - edge1 pass_serial=1;
  - edges 2–3 in DRAIN with bubble=1 and WANT_FREEZE=1;
  - NOTIFY cycle has SYS=1 for exactly one cycle;
  - RELEASE has WANT_FREEZE=0;
  - IDLE after 4 edges.
- SC op (notify_sim=0) -> identical timing with SYS held at 0 throughout.
- ld_valid=2'b10, ld_reg[1]=5'd8, src_b=8, uses_b=1 -> bubble=1, WANT_FREEZE=1. Clear ld_valid -> issue=1 next edge. src=0 with ld_reg=0 -> no hazard.
- stall held 3 cycles mid-DRAIN -> cnt, state, SYS and outputs unchanged; total drain becomes 4+3 edges.
- RESET asserted in NOTIFY -> next edge SYS=0, busy=0, bubble=1; the following syscall restarts the full 4-cycle drain.
